// File: rtl/aes_round_ops_if.sv
// Bus bundle for aes_round_ops: per-unit enables, operands, registered results and done flags.
// en_err is present only when AES_ROUND_ONEHOT_CHK_EN is defined.
interface aes_round_ops_if;
    localparam int unsigned STATE_W = 128;

    logic [STATE_W-1:0] ark_key;
    logic [STATE_W-1:0] ark_state;
    logic               ark_en;
    logic [STATE_W-1:0] ark_out;
    logic               ark_done;
    logic               sr_en;
    logic [STATE_W-1:0] sr_in;
    logic [STATE_W-1:0] sr_out;
    logic               sr_done;
    logic               mc_en;
    logic [STATE_W-1:0] mc_in;
    logic [STATE_W-1:0] mc_out;
    logic               mc_done;
`ifdef AES_ROUND_ONEHOT_CHK_EN
    logic               en_err;

    modport master (
        output ark_key, ark_state, ark_en, sr_en, sr_in, mc_en, mc_in,
        input  ark_out, ark_done, sr_out, sr_done, mc_out, mc_done, en_err
    );
    modport slave (
        input  ark_key, ark_state, ark_en, sr_en, sr_in, mc_en, mc_in,
        output ark_out, ark_done, sr_out, sr_done, mc_out, mc_done, en_err
    );
`else
    modport master (
        output ark_key, ark_state, ark_en, sr_en, sr_in, mc_en, mc_in,
        input  ark_out, ark_done, sr_out, sr_done, mc_out, mc_done
    );
    modport slave (
        input  ark_key, ark_state, ark_en, sr_en, sr_in, mc_en, mc_in,
        output ark_out, ark_done, sr_out, sr_done, mc_out, mc_done
    );
`endif
endinterface

// File: rtl/aes_round_ops.sv
// Registered AES-128 linear round transforms (AddRoundKey, ShiftRows, MixColumns), one enable/done per unit.
// Optional enable-collision flag en_err when AES_ROUND_ONEHOT_CHK_EN is defined.
module aes_round_ops (
    input  logic           clk,
    input  logic           rst,
    aes_round_ops_if.slave bus
);
    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Byte k sits at [127-8k -: 8]; row = k mod 4, column = k div 4.
    function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [STATE_W-1:0] mix_columns(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    logic [STATE_W-1:0] w_ark_next;
    logic [STATE_W-1:0] w_sr_next;
    logic [STATE_W-1:0] w_mc_next;
    logic [STATE_W-1:0] r_ark_out;
    logic [STATE_W-1:0] r_sr_out;
    logic [STATE_W-1:0] r_mc_out;
    logic               r_ark_done;
    logic               r_sr_done;
    logic               r_mc_done;

    assign w_ark_next = bus.ark_state ^ bus.ark_key;
    assign w_sr_next  = shift_rows(bus.sr_in);
    assign w_mc_next  = mix_columns(bus.mc_in);

    // AddRoundKey unit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ark_out  <= '0;
            r_ark_done <= 1'b0;
        end else begin
            r_ark_done <= bus.ark_en;
            if (bus.ark_en) r_ark_out <= w_ark_next;
        end
    end

    // ShiftRows unit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr_out  <= '0;
            r_sr_done <= 1'b0;
        end else begin
            r_sr_done <= bus.sr_en;
            if (bus.sr_en) r_sr_out <= w_sr_next;
        end
    end

    // MixColumns unit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mc_out  <= '0;
            r_mc_done <= 1'b0;
        end else begin
            r_mc_done <= bus.mc_en;
            if (bus.mc_en) r_mc_out <= w_mc_next;
        end
    end

    assign bus.ark_out  = r_ark_out;
    assign bus.ark_done = r_ark_done;
    assign bus.sr_out   = r_sr_out;
    assign bus.sr_done  = r_sr_done;
    assign bus.mc_out   = r_mc_out;
    assign bus.mc_done  = r_mc_done;

`ifdef AES_ROUND_ONEHOT_CHK_EN
    logic [1:0] w_en_cnt;
    logic       r_en_err;

    assign w_en_cnt = 2'(bus.ark_en) + 2'(bus.sr_en) + 2'(bus.mc_en);

    // Flags any edge that samples two or more enables high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_en_err <= 1'b0;
        else      r_en_err <= (w_en_cnt >= 2'd2);
    end

    assign bus.en_err = r_en_err;
`endif
endmodule

// File: tb/tb_aes_round_ops.sv
// Scoreboard bench for aes_round_ops: FIPS-197 vectors plus randomized traffic against a matrix/GF reference model.
// Define AES_ROUND_ONEHOT_CHK_EN to also check en_err.
module tb_aes_round_ops;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_round_ops_if bus();
    aes_round_ops dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    int unsigned   cyc   = 0;
    logic [127:0]  q  [3][$];
    int unsigned   qc [3][$];
    logic [127:0]  last [3];
    logic [7:0]    coef [4];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (state as 4x4 byte matrix [row][col]) ----------------
    function automatic logic [3:0][3:0][7:0] to_m(input logic [127:0] v);
        logic [3:0][3:0][7:0] m;
        for (int k = 0; k < 16; k++) m[k%4][k/4] = v[127-8*k -: 8];
        return m;
    endfunction

    function automatic logic [127:0] from_m(input logic [3:0][3:0][7:0] m);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = m[k%4][k/4];
        return v;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011B << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_sr(input logic [127:0] v);
        logic [3:0][3:0][7:0] s, o;
        s = to_m(v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[r][c] = s[r][(c + r) % 4];
        return from_m(o);
    endfunction

    function automatic logic [127:0] ref_mc(input logic [127:0] v);
        logic [3:0][3:0][7:0] s, o;
        s = to_m(v);
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 4; c++) begin
                o[i][c] = 8'h00;
                for (int j = 0; j < 4; j++) o[i][c] ^= gmul(coef[(j - i + 4) % 4], s[j][c]);
            end
        return from_m(o);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [127:0] e_ark, input logic [127:0] e_sr, input logic [127:0] e_mc);
        if (bus.ark_en) begin q[0].push_back(e_ark); qc[0].push_back(cyc); end
        if (bus.sr_en)  begin q[1].push_back(e_sr);  qc[1].push_back(cyc); end
        if (bus.mc_en)  begin q[2].push_back(e_mc);  qc[2].push_back(cyc); end
    endtask

    task automatic commit_model();
        commit(bus.ark_state ^ bus.ark_key, ref_sr(bus.sr_in), ref_mc(bus.mc_in));
    endtask

    // ---------------- monitor ----------------
    task automatic check_unit(input int u, input string nm, input logic done, input logic [127:0] out);
        logic         due;
        logic [127:0] e;
        due = (qc[u].size() != 0) && (qc[u][0] < cyc);
        n_cmp++;
        if (due) begin
            e = q[u].pop_front();
            void'(qc[u].pop_front());
            last[u] = e;
            if (!done || out !== e) begin
                n_bad++;
                $display("FAIL %s_result: got done=%0b out=%h, want done=1 out=%h", nm, done, out, e);
            end
        end else if (done || out !== last[u]) begin
            n_bad++;
            $display("FAIL %s_hold: got done=%0b out=%h, want done=0 out=%h", nm, done, out, last[u]);
        end
    endtask

    task automatic check_zero(input string nm, input logic done, input logic [127:0] out);
        n_cmp++;
        if (done !== 1'b0 || out !== 128'h0) begin
            n_bad++;
            $display("FAIL %s_reset: got done=%0b out=%h, want done=0 out=0", nm, done, out);
        end
    endtask

`ifdef AES_ROUND_ONEHOT_CHK_EN
    logic exp_err;
    always @(posedge clk or negedge rst) begin
        if (!rst) exp_err <= 1'b0;
        else      exp_err <= (int'(bus.ark_en) + int'(bus.sr_en) + int'(bus.mc_en)) >= 2;
    end
`endif

    always @(negedge clk) begin
        if (!rst) begin
            check_zero("ark", bus.ark_done, bus.ark_out);
            check_zero("sr",  bus.sr_done,  bus.sr_out);
            check_zero("mc",  bus.mc_done,  bus.mc_out);
            for (int u = 0; u < 3; u++) last[u] = 128'h0;
        end else begin
            check_unit(0, "ark", bus.ark_done, bus.ark_out);
            check_unit(1, "sr",  bus.sr_done,  bus.sr_out);
            check_unit(2, "mc",  bus.mc_done,  bus.mc_out);
        end
`ifdef AES_ROUND_ONEHOT_CHK_EN
        n_cmp++;
        if (bus.en_err !== (rst ? exp_err : 1'b0)) begin
            n_bad++;
            $display("FAIL en_err: got %0b want %0b", bus.en_err, rst ? exp_err : 1'b0);
        end
`endif
    end

    // ---------------- stimulus ----------------
    initial begin
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int u = 0; u < 3; u++) last[u] = 128'h0;
        bus.ark_en = 1'b0; bus.sr_en = 1'b0; bus.mc_en = 1'b0;
        bus.ark_key = '0; bus.ark_state = '0; bus.sr_in = '0; bus.mc_in = '0;

        #2 rst = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // AddRoundKey FIPS-197 vector, single-cycle pulse then inputs change while idle
        tick();
        bus.ark_state = 128'h3243f6a8885a308d313198a2e0370734;
        bus.ark_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        bus.ark_en    = 1'b1;
        commit(128'h193de3bea0f4e22b9ac68d2ae9f84808, '0, '0);
        tick();
        bus.ark_en = 1'b0;
        bus.ark_state = rnd128(); bus.ark_key = rnd128();
        tick();

        // ShiftRows FIPS-197 vector
        bus.sr_in = 128'hd42711aee0bf98f1b8b45de51e415230;
        bus.sr_en = 1'b1;
        commit('0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, '0);
        tick();
        bus.sr_en = 1'b0;
        bus.sr_in = rnd128();

        // MixColumns held high for 3 cycles with changing input
        tick();
        bus.mc_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        bus.mc_en = 1'b1;
        commit('0, '0, 128'h046681e5e0cb199a48f8d37a2806264c);
        tick();
        bus.mc_in = 128'hdb135345f20a225c01010101c6c6c6c6;
        commit('0, '0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
        tick();
        bus.mc_in = 128'hd4d4d4d52d26314c01010101c6c6c6c6;
        commit('0, '0, 128'hd5d5d7d64d7ebdf801010101c6c6c6c6);
        tick();
        bus.mc_en = 1'b0;
        bus.mc_in = rnd128();
        tick();

`ifdef AES_ROUND_ONEHOT_CHK_EN
        // Enable collision: both units still compute
        bus.ark_state = 128'h3243f6a8885a308d313198a2e0370734;
        bus.ark_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        bus.sr_in     = 128'hd42711aee0bf98f1b8b45de51e415230;
        bus.ark_en = 1'b1; bus.sr_en = 1'b1;
        commit(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd4bf5d30e0b452aeb84111f11e2798e5, '0);
        tick();
        bus.ark_en = 1'b0; bus.sr_en = 1'b0;
        tick(); tick();
`endif

        // Reset asserted while ark_en is high: no pending result survives
        bus.ark_state = rnd128(); bus.ark_key = rnd128();
        bus.ark_en = 1'b1;
        commit_model();
        #2 rst = 1'b0;
        for (int u = 0; u < 3; u++) begin q[u].delete(); qc[u].delete(); end
        #1;
        check_zero("ark_async", bus.ark_done, bus.ark_out);
        check_zero("sr_async",  bus.sr_done,  bus.sr_out);
        check_zero("mc_async",  bus.mc_done,  bus.mc_out);
        tick(); tick();
        rst = 1'b1;
        bus.ark_state = rnd128(); bus.ark_key = rnd128();
        commit_model();
        tick();
        bus.ark_en = 1'b0;
        bus.ark_state = rnd128();
        tick();

        // Randomized traffic, inputs change every cycle whether enabled or not
        for (int i = 0; i < 300; i++) begin
            bus.ark_en = ($urandom_range(0, 2) == 0);
            bus.sr_en  = ($urandom_range(0, 2) == 0);
            bus.mc_en  = ($urandom_range(0, 2) == 0);
            bus.ark_state = rnd128(); bus.ark_key = rnd128();
            bus.sr_in = rnd128(); bus.mc_in = rnd128();
            commit_model();
            tick();
        end

        bus.ark_en = 1'b0; bus.sr_en = 1'b0; bus.mc_en = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            n_cmp++;
            if (q[u].size() != 0) begin
                n_bad++;
                $display("FAIL drain_unit%0d: got %0d outstanding results, want 0", u, q[u].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_round_ops.md
# aes_round_ops

Register-bank of the three linear AES-128 round transforms used by the encryption round controller: AddRoundKey, ShiftRows and MixColumns. Each unit has its own enable/done pair and a registered 128-bit output. The controller sequences them one at a time, and SubBytes (combinational, external) sits between AddRoundKey and ShiftRows. The block holds no round counter or key schedule; it only transforms and registers.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock for all registers
- rst  in  1  asynchronous, active-low reset; clears all registers to zero
- ark_key  in  128  round key
- ark_state  in  128  state to be XORed with the key
- ark_en  in  1  AddRoundKey enable
- ark_out  out  128  registered AddRoundKey result
- ark_done  out  1  AddRoundKey result valid
- sr_en  in  1  ShiftRows enable
- sr_in  in  128  state to shift
- sr_out  out  128  registered ShiftRows result
- sr_done  out  1  ShiftRows result valid
- mc_en  in  1  MixColumns enable
- mc_in  in  128  state to mix
- mc_out  out  128  registered MixColumns result
- mc_done  out  1  MixColumns result valid
- en_err  out  1  enable-collision flag; present only with AES_ROUND_ONEHOT_CHK_EN

## Operation
- State layout follows FIPS-197 column-major order:
  - byte k occupies bits [127-8k -: 8]
  - row r = k mod 4, column c = k div 4
  - byte 0 is the MSB byte.
- AddRoundKey: ark_out = ark_state XOR ark_key, bitwise over all 128 bits.
- ShiftRows: output byte (r,c) = input byte (r,(c+r) mod 4). Row 0 is unchanged and rows 1/2/3 rotate left by 1/2/3.
- MixColumns: each column [a0..a3] is multiplied by the circulant matrix rows {02,03,01,01}, {01,02,03,01}, {01,01,02,03}, {03,01,01,02} over GF(2^8).
  - Reduction polynomial is 0x11B.
  - xtime(a) = (a<<1) XOR (a[7] ? 0x1B : 0), taken to 8 bits.
  - 03·a = xtime(a) XOR a.
  - All arithmetic is 8-bit, with no carries between bytes.
- The three units are fully independent. Simultaneous enables are legal, and each unit computes from its own inputs.
- The round controller guarantees that at most one enable is high at a time.

## Timing
- Reset (rst=0, asynchronous): all *_out = 128'h0, all *_done = 0, en_err = 0. Outputs stay there until the first clock edge after rst returns to 1.
- Per unit, at each rising edge:
  - if en=1: out <= f(inputs), done <= 1
  - if en=0: out holds its value, done <= 0
- Latency is 1 cycle: done rises on the edge that samples en=1, and the result is valid in the same cycle that done is high.
- While en is held high, the output re-evaluates every cycle with the current inputs and done stays 1.
- done falls on the first edge at which en is sampled 0. The output value persists after done falls.
- Input changes while en=0 have no effect on the outputs.
- If reset is asserted mid-operation, outputs and done clear immediately. There is no pending result after reset.

## Configuration
- AES_ROUND_ONEHOT_CHK_EN defined:
  - en_err port exists.
  - en_err is registered: it is set to 1 at any edge where two or more of ark_en/sr_en/mc_en are sampled high, and otherwise cleared to 0.
  - en_err is cleared by reset.
  - Datapath behaviour is unchanged.
- Not defined: en_err port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: drive rst=0 mid-run with ark_en=1 -> all outputs 0 and all done 0 immediately. After release, the first enabled edge produces results.
- AddRoundKey (FIPS-197 B):
  - Stimulus: state 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, ark_en pulsed 1 cycle.
  - Response: next cycle ark_out = 193de3bea0f4e22b9ac68d2ae9f84808 and ark_done=1. One cycle later ark_done=0 and ark_out is held.
- ShiftRows: sr_in d42711aee0bf98f1b8b45de51e415230, sr_en=1 -> sr_out d4bf5d30e0b452aeb84111f11e2798e5, with sr_done high one cycle after enable.
- MixColumns:
  - mc_in d4bf5d30e0b452aeb84111f11e2798e5 -> mc_out 046681e5e0cb199a48f8d37a2806264c.
  - Single-column check: column db135345 -> 8e4da1bc.
- Hold and re-evaluation:
  - With en held high for 3 cycles and the input changed each cycle, done stays 1 and the output tracks each input with 1-cycle lag.
  - With en=0, changing the inputs leaves the outputs constant.
- With AES_ROUND_ONEHOT_CHK_EN: ark_en=sr_en=1 for one edge -> en_err=1 for exactly one cycle, and both units still produce correct results.
